// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);

    localparam int c_BAUD_DIV = CLK_FREQ / BAUD;
    localparam int c_CW       = (c_BAUD_DIV > 1) ? $clog2(c_BAUD_DIV) : 1;
    localparam int c_AW       = $clog2(DEPTH);

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(c_BAUD_DIV - 1);
    localparam logic [c_CW-1:0] c_BAUD_ONE  = c_CW'(1);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // FIFO storage and status
    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;

    // Transmitter state
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_tx_nxt;
    logic            w_pop;
    logic            w_wr_accept;
    logic            w_baud_last;
    logic [7:0]      w_head;
    logic [c_AW:0]   w_count_nxt;

    // Acceptance looks only at registered full, so a same-edge pop cannot make room.
    assign w_wr_accept = wr_en & ~r_full;
    assign w_baud_last = (r_baud_cnt == c_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_accept, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_DEPTH);
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= wr_en & r_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // tx is registered, so each branch sets the line level for the coming cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = c_S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_S_START: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = c_S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                    w_tx_nxt   = 1'b0;
                end
            end
            c_S_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = c_S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                end
            end
            c_S_STOP: begin
                if (w_baud_last) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = c_S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + c_BAUD_ONE;
                    w_tx_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = (r_state != c_S_IDLE);
    assign tx       = r_tx;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; BAUD_DIV = CLK_FREQ/BAUD with integer truncation (434 at defaults).
REQ-003 Parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr_en  input  1  byte-write strobe from the control stage, sampled each clock.
REQ-007 wr_data  input  8  byte to be queued, valid when wr_en=1.
REQ-008 full  output  1  registered; 1 when count==DEPTH.
REQ-009 empty  output  1  registered; 1 when count==0.
REQ-010 count  output  log2(DEPTH)+1  registered number of queued bytes, not including the byte being shifted out.
REQ-011 overflow  output  1  one-cycle pulse when a write is rejected.
REQ-012 busy  output  1  1 whenever the FSM is not in IDLE.
REQ-013 tx  output  1  registered serial line, 8N1, idle high.

Function
REQ-014 A write is accepted iff wr_en=1 and full=0 at the sampling edge; the byte is stored at the write pointer, which then advances modulo DEPTH.
REQ-015 When wr_en=1 and full=1, the byte is discarded, FIFO contents are unchanged, and overflow=1 for exactly the next cycle.
REQ-016 A full FIFO rejects a write even when a pop occurs on the same edge; full is evaluated from registered state only.
REQ-017 A write and a pop on the same edge leave count unchanged, and both pointers advance.
REQ-018 Read and write pointers wrap from DEPTH-1 to 0 with no loss or duplication of bytes.
REQ-019 The FSM has four states: IDLE, START, DATA, STOP; a baud counter counts 0..BAUD_DIV-1 in every non-IDLE state, and a bit index counts 0..7 in DATA.
REQ-020 In IDLE, tx=1; when empty=0, the FSM pops the head byte into a shift register, enters START, and drives tx=0 on the same edge.
REQ-021 START: tx=0 for BAUD_DIV cycles, then the FSM enters DATA.
REQ-022 DATA: tx carries the shift-register bit 0 for BAUD_DIV cycles per bit, sending bits LSB first; after bit 7 the FSM enters STOP.
REQ-023 STOP: tx=1 for BAUD_DIV cycles.
REQ-024 On the last STOP cycle, if empty=0, the FSM pops the next byte and enters START directly, with no idle gap; otherwise it enters IDLE.
REQ-025 Every frame lasts exactly 10*BAUD_DIV cycles; back-to-back frames are contiguous.
REQ-026 Latency: a write accepted at edge E0 into an empty FIFO with the FSM in IDLE gives tx=0 after edge E1.
REQ-027 The byte in transmission is unaffected by any later writes or overflows.
REQ-028 Bytes are transmitted in exact acceptance order.

Reset
REQ-029 With rst=1 at a clock edge, the block sets: tx=1, busy=0, full=0, empty=1, count=0, overflow=0, both pointers=0, state IDLE, baud counter=0, bit index=0.
REQ-030 Reset mid-frame aborts the frame immediately: tx returns high on the reset edge, and all queued bytes are discarded.
REQ-031 While rst=1, wr_en is ignored; the first write is accepted on the first edge with rst=0.

Verification (bench parameters CLK_FREQ=1600, BAUD=100, so BAUD_DIV=16; DEPTH=4)
REQ-032 Single byte: write 0xA5 to an idle block -> tx=0 one cycle later for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then tx=1 for 16 cycles; busy falls after 160 cycles.
REQ-033 Burst: write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames totalling 480 cycles, in order 0x01, 0x02, 0x03, with no idle gap.
REQ-034 Overflow: while frame 0x10 is shifting, write 0x11..0x15 -> 0x11..0x14 are accepted and full=1; 0x15 gives one overflow pulse; the serial output is 0x10..0x14.
REQ-035 Simultaneous events: write on the same edge as a pop at end of STOP with count=2 -> count stays 2, and order is preserved.
REQ-036 Wrap: 10 single writes spaced one frame apart -> all 10 bytes are received correctly across pointer wrap-around.
REQ-037 Reset mid-frame: assert rst for 1 cycle during bit 3 of 0x5A with 2 bytes queued -> tx=1, count=0, and busy=0 next cycle; no further start bit until a new write.
